// File: rtl/sample_stream_feeder.sv
// ADC sample capture FIFO with paced single-cycle sample/valid re-emission.
// Flushes on enable edges and reports dropped samples for status readback.
module sample_stream_feeder #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          avl_clk_i,
  input  logic                          avl_reset_i,
  input  logic [DATA_W-1:0]             adc_data_i,
  input  logic                          adc_valid_i,
  input  logic                          acq_en_i,
  input  logic [7:0]                    gap_i,
  input  logic                          clr_overflow_i,
  output logic [DATA_W-1:0]             sample_o,
  output logic                          sample_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic [CNT_W-1:0]              drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_nstate;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic              r_en;
  logic [7:0]        r_gap_cnt;
  logic [DATA_W-1:0] r_sample;
  logic              r_valid;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic w_rise;
  logic w_flush;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_req;

  assign w_rise  = acq_en_i & ~r_en;
  assign w_flush = ~acq_en_i | w_rise;
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_req  = acq_en_i & adc_valid_i;
  assign w_pop  = (w_nstate == S_EMIT);
  assign w_push = w_req & (w_rise | ~w_full | w_pop);
  assign w_drop = w_req & ~w_push;

  always_comb begin
    w_nstate = r_state;
    if (!acq_en_i) begin
      w_nstate = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty && !w_rise)
            w_nstate = S_EMIT;
        end
        S_EMIT: begin
          if (gap_i != 8'd0)
            w_nstate = S_GAP;
          else if (!w_empty)
            w_nstate = S_EMIT;
          else
            w_nstate = S_IDLE;
        end
        S_GAP: begin
          if (r_gap_cnt <= 8'd1)
            w_nstate = w_empty ? S_IDLE : S_EMIT;
        end
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      r_state <= S_IDLE;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_en    <= acq_en_i;
    end
  end

  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      r_gap_cnt <= 8'd0;
    end else if (!acq_en_i) begin
      r_gap_cnt <= 8'd0;
    end else if (r_state == S_EMIT) begin
      r_gap_cnt <= gap_i;
    end else if (r_state == S_GAP && r_gap_cnt != 8'd0) begin
      r_gap_cnt <= r_gap_cnt - 8'd1;
    end
  end

  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (w_flush) begin
      // A sample arriving with the enable edge survives the flush.
      r_rd <= '0;
      r_wr <= {{AW{1'b0}}, w_push};
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge avl_clk_i) begin
    if (w_push)
      r_mem[w_flush ? '0 : r_wr[AW-1:0]] <= adc_data_i;
  end

  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      r_valid  <= 1'b0;
      r_sample <= '0;
    end else begin
      r_valid <= w_pop;
      if (w_pop)
        r_sample <= r_mem[r_rd[AW-1:0]];
    end
  end

  always_ff @(posedge avl_clk_i or negedge avl_reset_i) begin
    if (!avl_reset_i) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr_overflow_i) begin
      r_ovf      <= w_drop;
      r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (!(&r_drop_cnt))
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign fifo_level_o   = r_wr - r_rd;
  assign overflow_o     = r_ovf;
  assign drop_cnt_o     = r_drop_cnt;

endmodule

// File: tb/tb_sample_stream_feeder.sv
// Directed bench for sample_stream_feeder: pacing, overflow,
// enable flush, full push+pop and asynchronous reset.
module tb_sample_stream_feeder;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic        vld;
  logic        en;
  logic [7:0]  gap;
  logic        clr;
  logic [15:0] sample;
  logic        svalid;
  logic [4:0]  level;
  logic        ovf;
  logic [15:0] drops;

  int n_tests;
  int n_fail;
  int np;
  int pidx [32];
  logic [15:0] pdat [32];
  logic seen;

  sample_stream_feeder dut (
    .avl_clk_i      (clk),
    .avl_reset_i    (rst_n),
    .adc_data_i     (data),
    .adc_valid_i    (vld),
    .acq_en_i       (en),
    .gap_i          (gap),
    .clr_overflow_i (clr),
    .sample_o       (sample),
    .sample_valid_o (svalid),
    .fifo_level_o   (level),
    .overflow_o     (ovf),
    .drop_cnt_o     (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rec(input int c);
    if (svalid && np < 32) begin
      pidx[np] = c;
      pdat[np] = sample;
      np++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; en = 1'b0; vld = 1'b0;
    data = '0; gap = '0; clr = 1'b0;
    repeat (3) step();
    chk("rst_sample", sample, 0);
    chk("rst_valid", svalid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drops", drops, 0);
    rst_n = 1'b1;
    step();

    // reset mid-stream
    en = 1'b1; gap = 8'd255;
    for (int c = 0; c < 6; c++) begin
      vld = 1'b1; data = 16'h0050 + 16'(c);
      step();
    end
    vld = 1'b0;
    chk("t1_level5", level, 5);
    chk("t1_sample", sample, 16'h0050);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_sample", sample, 0);
    chk("t1_async_level", level, 0);
    chk("t1_async_valid", svalid, 0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      seen = seen | svalid;
    end
    chk("t1_nopulse", seen, 0);
    chk("t1_empty", level, 0);
    en = 1'b0;
    step();

    // gap spacing, gap=2
    gap = 8'd2; np = 0;
    for (int c = 0; c < 20; c++) begin
      en = 1'b1; vld = (c < 4); data = 16'(c + 1);
      step();
      rec(c);
    end
    chk("t2_count", np, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_idx%0d", k), pidx[k], 1 + 3 * k);
      chk($sformatf("t2_dat%0d", k), pdat[k], k + 1);
    end
    chk("t2_level", level, 0);
    en = 1'b0; vld = 1'b0;
    step();

    // back-to-back, gap=0
    gap = 8'd0; np = 0;
    for (int c = 0; c < 16; c++) begin
      en = 1'b1; vld = (c < 8); data = 16'h0010 + 16'(c);
      step();
      rec(c);
    end
    chk("t3_count", np, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_idx%0d", k), pidx[k], 1 + k);
      chk($sformatf("t3_dat%0d", k), pdat[k], 16'h0010 + k);
    end
    chk("t3_level", level, 0);
    en = 1'b0; vld = 1'b0;
    step();

    // overflow, gap=255
    gap = 8'd255;
    for (int c = 0; c < 20; c++) begin
      en = 1'b1; vld = 1'b1; data = 16'h0060 + 16'(c);
      step();
    end
    vld = 1'b0;
    chk("t4_ovf", ovf, 1);
    chk("t4_drops", drops, 3);
    chk("t4_level", level, 16);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clr_ovf", ovf, 0);
    chk("t4_clr_drops", drops, 0);
    clr = 1'b1; vld = 1'b1;
    step();
    clr = 1'b0; vld = 1'b0;
    chk("t4_win_ovf", ovf, 1);
    chk("t4_win_drops", drops, 1);
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_flush_level", level, 0);
    chk("t4_flush_ovf", ovf, 0);

    // full FIFO with coincident push and pop, gap=20
    gap = 8'd20;
    for (int c = 0; c < 25; c++) begin
      en = 1'b1;
      vld = (c <= 16) || (c == 22);
      data = 16'h0100 + 16'(c);
      step();
      if (c == 16) chk("t6_full", level, 16);
      if (c == 22) begin
        chk("t6_valid", svalid, 1);
        chk("t6_sample", sample, 16'h0101);
        chk("t6_level", level, 16);
        chk("t6_ovf", ovf, 0);
      end
    end
    chk("t6_drops", drops, 0);
    en = 1'b0; vld = 1'b0;
    step();

    // enable toggle mid-GAP, gap=4
    gap = 8'd4; np = 0;
    for (int c = 0; c < 15; c++) begin
      en = !(c == 4 || c == 5);
      vld = (c <= 2) || (c >= 4 && c <= 7);
      if (c <= 2) data = 16'h0021 + 16'(c);
      else if (c <= 5) data = 16'h0031 + 16'(c - 4);
      else data = 16'h0041 + 16'(c - 6);
      step();
      rec(c);
      if (c == 3) chk("t5_level_gap", level, 2);
      if (c == 5) begin
        chk("t5_flushed", level, 0);
        chk("t5_hold", sample, 16'h0021);
      end
    end
    chk("t5_count", np, 3);
    chk("t5_idx0", pidx[0], 1);
    chk("t5_dat0", pdat[0], 16'h0021);
    chk("t5_idx1", pidx[1], 7);
    chk("t5_dat1", pdat[1], 16'h0041);
    chk("t5_idx2", pidx[2], 12);
    chk("t5_dat2", pdat[2], 16'h0042);
    en = 1'b0; vld = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
